cache_set_assoc: RTL and testbench

CACHE_SET_ASSOC -- requirements
Module: cache_set_assoc

---
 rtl/cache_set_assoc_pkg.sv | 20 ++
 rtl/cache_set_assoc_mem.sv | 33 +++
 rtl/cache_set_assoc.sv | 220 ++++++++++++++++++++++
 tb/tb_cache_set_assoc.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_set_assoc_pkg.sv
// Shared definitions for the 2-way set-associative cache.
// Holds the controller state encoding and the default geometry
// (index, tag and data widths) used by the top level.
package cache_set_assoc_pkg;

    localparam int INDEX_W_DEFAULT = 3;
    localparam int TAG_W_DEFAULT   = 2;
    localparam int DATA_W_DEFAULT  = 16;

    // Controller states: accept, compare tags, evict a dirty victim,
    // fetch the missing word, then report completion.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITEBACK,
        ST_REFILL,
        ST_RESP
    } state_e;

endpackage

// File: rtl/cache_set_assoc_mem.sv
// mem_block: synchronous single-port RAM with a registered read port.
// Ports:
//   clk   - clock; the write and the read both happen on its rising edge
//   we    - write enable for the addressed word
//   addr  - word address, shared by the read and the write
//   wdata - write data
//   rdata - word read at the previous edge (read-before-write)
// The contents are not reset.
module mem_block #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage array and output register; a write returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cache_set_assoc.sv
// cache_set_assoc: 2-way set-associative, write-back, write-allocate cache.
// Each line holds one word.
// Ports:
//   clk, rst_n           - clock; synchronous active-low reset
//   cpu_req/we/addr/wdata - CPU request, accepted only while idle
//   cpu_rdata, cpu_done  - read data and its one-cycle completion pulse
//   cpu_busy             - high while a request is being serviced
//   hit                  - pulses with cpu_done when the access hit
//   mem_*                - backing-memory request/acknowledge handshake
// Each way has one mem_block holding {tag, data}. The valid, dirty and
// LRU bits are flops so that reset clears them.
module cache_set_assoc
    import cache_set_assoc_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEFAULT,
    parameter int TAG_W   = TAG_W_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [TAG_W+INDEX_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic                     cpu_done,
    output logic                     cpu_busy,
    output logic                     hit,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [TAG_W+INDEX_W-1:0] mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ack
);

    localparam int SETS   = 2 ** INDEX_W;
    localparam int ADDR_W = TAG_W + INDEX_W;
    localparam int LINE_W = TAG_W + DATA_W;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   we_q, we_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   victim_q, victim_d;
    logic [1:0][SETS-1:0]   valid_q, valid_d;
    logic [1:0][SETS-1:0]   dirty_q, dirty_d;
    logic [SETS-1:0]        lru_q, lru_d;
    logic                   done_q, done_d;
    logic                   hit_q, hit_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;

    logic [TAG_W-1:0]       tag_l;
    logic [INDEX_W-1:0]     idx_l;
    logic [INDEX_W-1:0]     ram_addr;
    logic [1:0]             ram_we;
    logic [LINE_W-1:0]      ram_wdata;
    logic [LINE_W-1:0]      ram_rdata [2];
    logic [TAG_W-1:0]       way_tag   [2];
    logic [DATA_W-1:0]      way_data  [2];
    logic [1:0]             way_hit;
    logic                   hit_way;
    logic                   victim_sel;

    assign tag_l = addr_q[ADDR_W-1:INDEX_W];
    assign idx_l = addr_q[INDEX_W-1:0];

    // One RAM per way. The RAM is read every cycle, so its output always
    // shows the set of the request being serviced.
    for (genvar w = 0; w < 2; w++) begin : g_way
        mem_block #(
            .WIDTH (LINE_W),
            .DEPTH (SETS)
        ) u_ram (
            .clk   (clk),
            .we    (ram_we[w]),
            .addr  (ram_addr),
            .wdata (ram_wdata),
            .rdata (ram_rdata[w])
        );
        assign way_tag[w]  = ram_rdata[w][LINE_W-1:DATA_W];
        assign way_data[w] = ram_rdata[w][DATA_W-1:0];
        assign way_hit[w]  = valid_q[w][idx_l] && (way_tag[w] == tag_l);
    end

    // Next-state and output logic. The LRU bit of a set names the way to
    // replace next. A write miss installs its word in RESP, which is
    // reached either directly or after the victim has been written back.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        victim_d   = victim_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        lru_d      = lru_q;
        done_d     = 1'b0;
        hit_d      = 1'b0;
        rdata_d    = rdata_q;
        ram_addr   = (state_q == ST_IDLE) ? cpu_addr[INDEX_W-1:0] : idx_l;
        ram_we     = 2'b00;
        ram_wdata  = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        hit_way    = way_hit[1];
        victim_sel = !valid_q[0][idx_l] ? 1'b0 :
                     !valid_q[1][idx_l] ? 1'b1 : lru_q[idx_l];

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (|way_hit) begin
                    done_d         = 1'b1;
                    hit_d          = 1'b1;
                    lru_d[idx_l]   = ~hit_way;
                    state_d        = ST_IDLE;
                    if (we_q) begin
                        ram_we[hit_way]         = 1'b1;
                        ram_wdata               = {tag_l, wdata_q};
                        dirty_d[hit_way][idx_l] = 1'b1;
                    end else begin
                        rdata_d = way_data[hit_way];
                    end
                end else begin
                    victim_d = victim_sel;
                    if (valid_q[victim_sel][idx_l] && dirty_q[victim_sel][idx_l]) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        state_d = we_q ? ST_RESP : ST_REFILL;
                    end
                end
            end
            ST_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {way_tag[victim_q], idx_l};
                mem_wdata = way_data[victim_q];
                if (mem_ack) begin
                    state_d = we_q ? ST_RESP : ST_REFILL;
                end
            end
            ST_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {tag_l, idx_l};
                if (mem_ack) begin
                    ram_we[victim_q]         = 1'b1;
                    ram_wdata                = {tag_l, mem_rdata};
                    valid_d[victim_q][idx_l] = 1'b1;
                    dirty_d[victim_q][idx_l] = 1'b0;
                    rdata_d                  = mem_rdata;
                    state_d                  = ST_RESP;
                end
            end
            ST_RESP: begin
                done_d       = 1'b1;
                lru_d[idx_l] = ~victim_q;
                state_d      = ST_IDLE;
                if (we_q) begin
                    ram_we[victim_q]         = 1'b1;
                    ram_wdata                = {tag_l, wdata_q};
                    valid_d[victim_q][idx_l] = 1'b1;
                    dirty_d[victim_q][idx_l] = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An abandoned transaction must not leave a partially written line.
        if (!rst_n) begin
            ram_we = 2'b00;
        end
    end

    // State register and line status bits; reset clears every flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            victim_q <= 1'b0;
            valid_q  <= '0;
            dirty_q  <= '0;
            lru_q    <= '0;
            done_q   <= 1'b0;
            hit_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            victim_q <= victim_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            lru_q    <= lru_d;
            done_q   <= done_d;
            hit_q    <= hit_d;
            rdata_q  <= rdata_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_done  = done_q;
    assign hit       = hit_q;
    assign cpu_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cache_set_assoc.sv
// Self-checking bench for cache_set_assoc.
// A memory model answers the backing-memory handshake and logs every
// accepted transfer. Each CPU request pushes its expected result to a
// scoreboard queue, which is popped whenever cpu_done pulses.
module tb_cache_set_assoc;

    localparam int INDEX_W = 3;
    localparam int TAG_W   = 2;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = TAG_W + INDEX_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_done;
    logic              cpu_busy;
    logic              hit;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    typedef struct {
        string             name;
        logic [DATA_W-1:0] rdata;
        logic              hit;
        bit                chk_data;
        int                lat;
        int                req_cycle;
    } exp_t;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } txn_t;

    exp_t              exp_q[$];
    txn_t              traffic[$];
    logic [DATA_W-1:0] backing [2**ADDR_W];
    int                checks = 0;
    int                failures = 0;
    int                cycle = 0;
    int                spurious = 0;
    int                ack_delay = 1;
    int                wait_cnt = 0;
    bit                zero_wait = 1'b0;
    bit                ack_hold = 1'b0;
    logic              ack_r = 1'b0;
    logic              ack_now;

    cache_set_assoc #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_done  (cpu_done),
        .cpu_busy  (cpu_busy),
        .hit       (hit),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    assign mem_ack   = zero_wait ? mem_req : ack_r;
    assign mem_rdata = backing[mem_addr];

    // Counts one comparison and reports it when it does not match.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Memory model: acknowledges after ack_delay idle cycles (or in the
    // same cycle when zero_wait is set) and logs each accepted transfer.
    always @(negedge clk) begin
        ack_r = 1'b0;
        if (!rst_n) begin
            wait_cnt = 0;
        end else if (mem_req && !zero_wait && !ack_hold) begin
            wait_cnt++;
            if (wait_cnt > ack_delay) begin
                ack_r    = 1'b1;
                wait_cnt = 0;
            end
        end else if (!mem_req) begin
            wait_cnt = 0;
        end
        ack_now = zero_wait ? mem_req : ack_r;
        if (rst_n && mem_req && ack_now) begin
            traffic.push_back('{mem_we, mem_addr, mem_wdata});
            if (mem_we) begin
                backing[mem_addr] = mem_wdata;
            end
        end
    end

    // Scoreboard consumer: each completion pulse is matched to the oldest
    // outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && cpu_done) begin
            if (exp_q.size() == 0) begin
                spurious++;
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput({e.name, "_hit"}, 32'(hit), 32'(e.hit));
                if (e.chk_data) begin
                    checkOutput({e.name, "_rdata"}, 32'(cpu_rdata), 32'(e.rdata));
                end
                if (e.lat > 0) begin
                    checkOutput({e.name, "_latency"}, cycle - e.req_cycle, e.lat);
                end
            end
        end
    end

    // Drives one request and waits for its completion. With extra set, a
    // second request (write 0x1F=0xDEAD) is held on cpu_req while busy.
    task automatic applyStimulus(input string name, input logic we,
                                 input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata,
                                 input logic [DATA_W-1:0] exp_rdata,
                                 input logic exp_hit, input int lat,
                                 input bit extra);
        exp_t e;
        int   n;
        @(negedge clk);
        e.name      = name;
        e.rdata     = exp_rdata;
        e.hit       = exp_hit;
        e.chk_data  = !we;
        e.lat       = lat;
        e.req_cycle = cycle;
        exp_q.push_back(e);
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_req   = 1'b1;
        @(posedge clk);
        #1;
        if (extra) begin
            cpu_we    = 1'b1;
            cpu_addr  = 5'h1F;
            cpu_wdata = 16'hDEAD;
            @(posedge clk);
            @(posedge clk);
            #1;
        end
        cpu_req = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checkOutput({name, "_timeout"}, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Compares logged transfer i against the expected direction/address/data.
    task automatic checkTxn(input string name, input int i, input logic we,
                            input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] data);
        if (traffic.size() > i) begin
            checkOutput({name, "_we_addr"}, 32'({traffic[i].we, traffic[i].addr}), 32'({we, addr}));
            if (we) begin
                checkOutput({name, "_wdata"}, 32'(traffic[i].data), 32'(data));
            end
        end else begin
            checkOutput({name, "_missing"}, traffic.size(), i + 1);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 2**ADDR_W; i++) begin
            backing[i] = 16'(16'h1000 + i);
        end
        backing[5] = 16'h1234;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_flags", 32'({cpu_done, hit, cpu_busy, mem_req, mem_we}), 0);
        checkOutput("rst_rdata", 32'(cpu_rdata), 0);
        checkOutput("rst_mem_addr_wdata", 32'({mem_addr, mem_wdata}), 0);
        rst_n = 1'b1;

        // Cold read miss, then a hit on the same address
        traffic.delete();
        applyStimulus("rd05_miss", 1'b0, 5'h05, '0, 16'h1234, 1'b0, 0, 1'b0);
        checkOutput("rd05_traffic_n", traffic.size(), 1);
        checkTxn("rd05_refill", 0, 1'b0, 5'h05, '0);
        traffic.delete();
        applyStimulus("rd05_hit", 1'b0, 5'h05, '0, 16'h1234, 1'b1, 2, 1'b0);

        // Write hit stays in the cache
        applyStimulus("wr05_hit", 1'b1, 5'h05, 16'hBEEF, '0, 1'b1, 2, 1'b0);
        applyStimulus("rd05_after_wr", 1'b0, 5'h05, '0, 16'hBEEF, 1'b1, 2, 1'b0);
        checkOutput("wr05_traffic_n", traffic.size(), 0);

        // Fill the second way of set 5, dirty it, then touch tag 0
        applyStimulus("rd0d_miss", 1'b0, 5'h0D, '0, 16'h100D, 1'b0, 0, 1'b0);
        applyStimulus("wr0d_hit", 1'b1, 5'h0D, 16'hCAFE, '0, 1'b1, 2, 1'b0);
        applyStimulus("rd05_touch", 1'b0, 5'h05, '0, 16'hBEEF, 1'b1, 2, 1'b0);

        // Tag 2 evicts the LRU way (tag 1, dirty)
        traffic.delete();
        applyStimulus("rd15_evict", 1'b0, 5'h15, '0, 16'h1015, 1'b0, 0, 1'b0);
        checkOutput("rd15_traffic_n", traffic.size(), 2);
        checkTxn("rd15_writeback", 0, 1'b1, 5'h0D, 16'hCAFE);
        checkTxn("rd15_refill", 1, 1'b0, 5'h15, '0);
        applyStimulus("rd05_kept", 1'b0, 5'h05, '0, 16'hBEEF, 1'b1, 2, 1'b0);
        traffic.delete();
        applyStimulus("rd0d_reload", 1'b0, 5'h0D, '0, 16'hCAFE, 1'b0, 0, 1'b0);
        checkOutput("rd0d_traffic_n", traffic.size(), 1);
        checkTxn("rd0d_refill", 0, 1'b0, 5'h0D, '0);

        // Write miss to an empty set: no fetch, 3-cycle completion
        traffic.delete();
        applyStimulus("wr03_miss", 1'b1, 5'h03, 16'h5A5A, '0, 1'b0, 3, 1'b0);
        checkOutput("wr03_traffic_n", traffic.size(), 0);
        applyStimulus("rd03_hit", 1'b0, 5'h03, '0, 16'h5A5A, 1'b1, 2, 1'b0);

        // Reset while REFILL waits for an acknowledge
        traffic.delete();
        ack_hold = 1'b1;
        @(negedge clk);
        cpu_we   = 1'b0;
        cpu_addr = 5'h07;
        cpu_req  = 1'b1;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("midrst_refill_req", 32'({mem_req, mem_we, mem_addr}), 32'({1'b1, 1'b0, 5'h07}));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_mem_req", 32'(mem_req), 0);
        checkOutput("midrst_busy", 32'(cpu_busy), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        ack_hold = 1'b0;
        checkOutput("midrst_traffic_n", traffic.size(), 0);
        applyStimulus("rd07_after_rst", 1'b0, 5'h07, '0, 16'h1007, 1'b0, 0, 1'b0);
        applyStimulus("rd03_after_rst", 1'b0, 5'h03, '0, 16'h1003, 1'b0, 0, 1'b0);

        // Zero-wait memory, with a request held while busy
        zero_wait = 1'b1;
        traffic.delete();
        applyStimulus("zw_rd0f", 1'b0, 5'h0F, '0, 16'h100F, 1'b0, 0, 1'b1);
        checkOutput("zw_rd0f_traffic_n", traffic.size(), 1);
        checkTxn("zw_rd0f_refill", 0, 1'b0, 5'h0F, '0);
        applyStimulus("zw_rd1f_dropped", 1'b0, 5'h1F, '0, 16'h101F, 1'b0, 0, 1'b0);
        applyStimulus("zw_rd0f_hit", 1'b0, 5'h0F, '0, 16'h100F, 1'b1, 2, 1'b0);

        repeat (5) @(negedge clk);
        checkOutput("spurious_done", spurious, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
